videomem_txn_scheduler: RTL and testbench

Transaction scheduler in front of the video-memory AXI master. It shares the master's single command channel (one-cycle init pulse, done pulse, error flag) between two requesters: the display fetch port and the frame-writer port. It arbitrates with display priority and a starvation guard, sequences each transaction, and applies a completion timeout. It returns per-requester acknowledgements, and it keeps transaction and error statistics for the status registers.

---
 rtl/videomem_txn_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_videomem_txn_scheduler.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/videomem_txn_scheduler.sv
// videomem_txn_scheduler
//
// Shares the single command channel of the video-memory AXI master between
// the display fetch port (reads) and the frame-writer port (writes). The
// display port has priority, but the writer is granted after STARVE_LIMIT
// consecutive display grants made while it was waiting. Each transaction
// gets one m_init pulse. It ends on m_done, or it is aborted with an error
// once TIMEOUT cycles pass without m_done. The owner then receives a
// one-cycle ack.
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | no transaction; arbitrate and latch the winner onto m_*
// ISSUE | m_init high for this single cycle; load the completion timer
// WAIT  | wait for m_done or timer expiry
// RESP  | owner ack pulse with ack_err; counters already updated
//
// Ports
//   ACLK, ARESET                   clock, synchronous active-high reset
//   disp_req/disp_addr             display read request (held until ack)
//   disp_ack/disp_rdata            display completion pulse, read data
//   wr_req/wr_addr/wr_wdata        writer request (held until ack)
//   wr_ack                         writer completion pulse
//   ack_err                        error status, valid with either ack
//   m_init/m_wr/m_addr/m_wdata     command to the AXI master
//   m_done/m_error/m_rdata         completion from the AXI master
//   busy                           high whenever not IDLE
//   txn_count/err_count            saturating completion / error counters
module videomem_txn_scheduler #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int TIMEOUT      = 1024,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_ack,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_wdata,
    output logic              wr_ack,
    output logic              ack_err,
    output logic              m_init,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_done,
    input  logic              m_error,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy,
    output logic [15:0]       txn_count,
    output logic [7:0]        err_count
);

    localparam int TMR_W = $clog2(TIMEOUT);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [STV_W-1:0]  starve_q, starve_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              disp_ack_q, disp_ack_d;
    logic              wr_ack_q, wr_ack_d;
    logic              ack_err_q, ack_err_d;
    logic              m_init_q, m_init_d;
    logic              m_wr_q, m_wr_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic [DATA_W-1:0] disp_rdata_q, disp_rdata_d;
    logic              busy_q, busy_d;
    logic [15:0]       txn_count_q, txn_count_d;
    logic [7:0]        err_count_q, err_count_d;

    logic              pick_wr;
    logic              rsp_err;

    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        tmr_d        = tmr_q;
        disp_ack_d   = 1'b0;
        wr_ack_d     = 1'b0;
        ack_err_d    = 1'b0;
        m_init_d     = 1'b0;
        m_wr_d       = m_wr_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        disp_rdata_d = disp_rdata_q;
        txn_count_d  = txn_count_q;
        err_count_d  = err_count_q;
        pick_wr      = wr_req & (~disp_req | (starve_q == STV_MAX));
        rsp_err      = m_done ? m_error : 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (disp_req | wr_req) begin
                    state_d   = ST_ISSUE;
                    m_init_d  = 1'b1;
                    m_wr_d    = pick_wr;
                    m_addr_d  = pick_wr ? wr_addr : disp_addr;
                    // Reads carry no payload; keep the data bus quiet.
                    m_wdata_d = pick_wr ? wr_wdata : '0;
                end
                // The guard only counts display grants that made the writer wait.
                if (!wr_req || pick_wr) begin
                    starve_d = '0;
                end else if (disp_req) begin
                    starve_d = starve_q + STV_W'(1);
                end
            end
            ST_ISSUE: begin
                tmr_d   = TMR_LOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // m_done takes precedence over expiry on the same cycle.
                if (m_done || tmr_q == '0) begin
                    state_d    = ST_RESP;
                    disp_ack_d = ~m_wr_q;
                    wr_ack_d   = m_wr_q;
                    ack_err_d  = rsp_err;
                    if (!m_wr_q) begin
                        disp_rdata_d = rsp_err ? '0 : m_rdata;
                    end
                    if (txn_count_q != 16'hFFFF) begin
                        txn_count_d = txn_count_q + 16'd1;
                    end
                    if (rsp_err && err_count_q != 8'hFF) begin
                        err_count_d = err_count_q + 8'd1;
                    end
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q      <= ST_IDLE;
            starve_q     <= '0;
            tmr_q        <= '0;
            disp_ack_q   <= 1'b0;
            wr_ack_q     <= 1'b0;
            ack_err_q    <= 1'b0;
            m_init_q     <= 1'b0;
            m_wr_q       <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            disp_rdata_q <= '0;
            busy_q       <= 1'b0;
            txn_count_q  <= '0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            tmr_q        <= tmr_d;
            disp_ack_q   <= disp_ack_d;
            wr_ack_q     <= wr_ack_d;
            ack_err_q    <= ack_err_d;
            m_init_q     <= m_init_d;
            m_wr_q       <= m_wr_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            disp_rdata_q <= disp_rdata_d;
            busy_q       <= busy_d;
            txn_count_q  <= txn_count_d;
            err_count_q  <= err_count_d;
        end
    end

    assign disp_ack   = disp_ack_q;
    assign disp_rdata = disp_rdata_q;
    assign wr_ack     = wr_ack_q;
    assign ack_err    = ack_err_q;
    assign m_init     = m_init_q;
    assign m_wr       = m_wr_q;
    assign m_addr     = m_addr_q;
    assign m_wdata    = m_wdata_q;
    assign busy       = busy_q;
    assign txn_count  = txn_count_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_videomem_txn_scheduler.sv
`timescale 1ns/1ps
module tb_videomem_txn_scheduler;
    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int TIMEOUT      = 8;
    localparam int STARVE_LIMIT = 4;

    logic              ACLK = 1'b0;
    logic              ARESET = 1'b1;
    logic              disp_req = 1'b0;
    logic [ADDR_W-1:0] disp_addr = '0;
    logic              disp_ack;
    logic [DATA_W-1:0] disp_rdata;
    logic              wr_req = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_wdata = '0;
    logic              wr_ack;
    logic              ack_err;
    logic              m_init;
    logic              m_wr;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_done = 1'b0;
    logic              m_error = 1'b0;
    logic [DATA_W-1:0] m_rdata = '0;
    logic              busy;
    logic [15:0]       txn_count;
    logic [7:0]        err_count;

    videomem_txn_scheduler #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack), .disp_rdata(disp_rdata),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_wdata(wr_wdata), .wr_ack(wr_ack),
        .ack_err(ack_err),
        .m_init(m_init), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_done(m_done), .m_error(m_error), .m_rdata(m_rdata),
        .busy(busy), .txn_count(txn_count), .err_count(err_count)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Requester, master responder and observation state.
    int disp_target = 0, wr_target = 0;
    int disp_done_n = 0, wr_done_n = 0;
    int resp_delay = 0;
    logic resp_err = 1'b0;
    logic [31:0] resp_rdata = '0;
    int ncyc = 0, init_cnt = 0, init_cyc = 0, ack_cnt = 0, ack_cyc = 0;
    logic last_init_wr = 1'b0, last_err = 1'b0;
    bit grants[$];
    bit chk_hold = 1'b0;
    bit preload_en = 1'b0;
    logic [15:0] preload_val = '0;

    // Requesters: hold req until the requested number of acks has arrived.
    initial forever begin
        @(negedge ACLK);
        if (disp_ack === 1'b1) disp_done_n++;
        if (wr_ack === 1'b1) wr_done_n++;
        disp_req = (disp_done_n < disp_target);
        wr_req   = (wr_done_n < wr_target);
    end

    // Master: m_done resp_delay cycles after each m_init (0 = never).
    initial begin
        int rcnt;
        int rcyc;
        rcnt = 0;
        rcyc = 0;
        forever begin
            @(negedge ACLK);
            rcyc++;
            m_done  = 1'b0;
            m_error = 1'b0;
            m_rdata = 32'hBAD00000 | 32'(rcyc);
            if (rcnt > 0) begin
                rcnt--;
                if (rcnt == 0) begin
                    m_done  = 1'b1;
                    m_error = resp_err;
                    m_rdata = resp_rdata;
                end
            end
            if (m_init === 1'b1 && resp_delay > 0) rcnt = resp_delay;
        end
    end

    // Observation log used by the literal checks.
    initial forever begin
        @(negedge ACLK);
        ncyc++;
        if (m_init === 1'b1) begin
            init_cnt++;
            init_cyc = ncyc;
            last_init_wr = m_wr;
            grants.push_back(m_wr);
        end
        if (disp_ack === 1'b1 || wr_ack === 1'b1) begin
            ack_cnt++;
            ack_cyc = ncyc;
            last_err = ack_err;
        end
    end

    // Reference model: transaction timeline in terms of cycles since grant.
    bit model_ok = 1'b0;
    logic e_busy, e_init, e_dack, e_wack, e_err, e_wr;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [15:0] e_txn;
    logic [7:0]  e_errc;

    initial begin
        int now_e, md_g, age, md_starve;
        bit md_active, md_resp, pick, rerr;
        now_e = 0; md_g = 0; md_starve = 0; md_active = 0; md_resp = 0;
        forever begin
            @(posedge ACLK);
            #1;
            now_e++;
            if (ARESET) begin
                model_ok = 1'b1;
                md_active = 0; md_resp = 0; md_starve = 0;
                e_busy = 0; e_init = 0; e_dack = 0; e_wack = 0; e_err = 0; e_wr = 0;
                e_addr = '0; e_wdata = '0; e_rdata = '0; e_txn = '0; e_errc = '0;
            end else begin
                e_dack = 0; e_wack = 0; e_err = 0;
                if (preload_en) e_txn = preload_val;
                if (md_resp) begin
                    md_resp = 0; md_active = 0; e_busy = 0;
                end else if (!md_active) begin
                    if (disp_req || wr_req) begin
                        pick = wr_req && (!disp_req || md_starve == STARVE_LIMIT);
                        md_starve = pick ? 0 : (wr_req ? md_starve + 1 : 0);
                        md_active = 1; md_g = now_e;
                        e_init = 1; e_busy = 1; e_wr = pick;
                        e_addr  = pick ? wr_addr : disp_addr;
                        e_wdata = pick ? wr_wdata : '0;
                    end else begin
                        md_starve = 0;
                    end
                end else begin
                    age = now_e - md_g;
                    e_init = 0;
                    if (age >= 2 && (m_done || age == TIMEOUT + 1)) begin
                        rerr = m_done ? m_error : 1'b1;
                        md_resp = 1;
                        e_err = rerr;
                        if (e_wr) e_wack = 1;
                        else begin
                            e_dack = 1;
                            e_rdata = rerr ? '0 : m_rdata;
                        end
                        if (e_txn != 16'hFFFF) e_txn = e_txn + 16'd1;
                        if (rerr && e_errc != 8'hFF) e_errc = e_errc + 8'd1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge ACLK);
        if (model_ok) begin
            chk("busy", busy, e_busy);
            chk("m_init", m_init, e_init);
            chk("disp_ack", disp_ack, e_dack);
            chk("wr_ack", wr_ack, e_wack);
            if (e_dack || e_wack) chk("ack_err", ack_err, e_err);
            chk("disp_rdata", disp_rdata, e_rdata);
            if (!chk_hold) chk("txn_count", txn_count, e_txn);
            chk("err_count", err_count, e_errc);
            if (e_busy) begin
                chk("m_wr", m_wr, e_wr);
                chk("m_addr", m_addr, e_addr);
                if (e_wr) chk("m_wdata", m_wdata, e_wdata);
            end
        end
    end

    task automatic wait_disp(input int n, input int lim);
        int k;
        k = 0;
        while (disp_done_n < n && k < lim) begin @(negedge ACLK); k++; end
        chk("disp_ack_wait", (disp_done_n >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_wr(input int n, input int lim);
        int k;
        k = 0;
        while (wr_done_n < n && k < lim) begin @(negedge ACLK); k++; end
        chk("wr_ack_wait", (wr_done_n >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        int ic0, a0, g0, k;
        logic [9:0] ord;

        repeat (3) @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("rst_busy", busy, 0);
        chk("rst_m_init", m_init, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_txn", txn_count, 0);
        chk("rst_rdata", disp_rdata, 0);

        // Single read.
        disp_addr = 32'h100; resp_delay = 3; resp_rdata = 32'hCAFE0001; resp_err = 1'b0;
        ic0 = init_cnt;
        disp_target = disp_target + 1;
        wait_disp(disp_target, 40);
        repeat (2) @(negedge ACLK);
        chk("t1_init_pulses", init_cnt - ic0, 1);
        chk("t1_m_wr", last_init_wr, 0);
        chk("t1_ack_latency", ack_cyc - init_cyc, 4);
        chk("t1_rdata", disp_rdata, 32'hCAFE0001);
        chk("t1_ack_err", last_err, 0);
        chk("t1_txn", txn_count, 1);

        // Contention with both requests held.
        disp_addr = 32'h2000; wr_addr = 32'h3000; wr_wdata = 32'h5A5A0001; resp_delay = 1;
        g0 = grants.size();
        disp_target = disp_target + 8;
        wr_target = wr_target + 2;
        wait_wr(wr_target, 200);
        repeat (2) @(negedge ACLK);
        chk("t2_grants", grants.size() - g0, 10);
        ord = '0;
        for (int i = 0; i < 10; i++) begin
            ord = {ord[8:0], (g0 + i < grants.size()) ? grants[g0 + i] : 1'b0};
        end
        chk("t2_order", ord, 10'b0000100001);
        chk("t2_txn", txn_count, 11);

        // Timeout, then a late m_done.
        disp_addr = 32'h400; resp_delay = 12;
        disp_target = disp_target + 1;
        wait_disp(disp_target, 60);
        chk("t3_ack_latency", ack_cyc - init_cyc, 9);
        chk("t3_ack_err", last_err, 1);
        chk("t3_err_count", err_count, 1);
        a0 = ack_cnt;
        repeat (8) @(negedge ACLK);
        chk("t3_no_late_ack", ack_cnt, a0);
        chk("t3_idle", busy, 0);

        // m_done with error on the timeout cycle.
        wr_addr = 32'h500; wr_wdata = 32'h0BAD0BAD; resp_delay = 8; resp_err = 1'b1;
        a0 = ack_cnt;
        wr_target = wr_target + 1;
        wait_wr(wr_target, 60);
        repeat (4) @(negedge ACLK);
        chk("t4_single_ack", ack_cnt - a0, 1);
        chk("t4_ack_latency", ack_cyc - init_cyc, 9);
        chk("t4_ack_err", last_err, 1);
        chk("t4_err_count", err_count, 2);

        // Reset during WAIT.
        resp_delay = 6; resp_err = 1'b0; resp_rdata = 32'h00000077; disp_addr = 32'h600;
        ic0 = init_cnt;
        disp_target = disp_target + 1;
        k = 0;
        while (init_cnt == ic0 && k < 40) begin @(negedge ACLK); k++; end
        chk("t5_init_seen", (init_cnt != ic0) ? 32'd1 : 32'd0, 32'd1);
        repeat (3) @(negedge ACLK);
        ARESET = 1'b1;
        disp_target = disp_done_n;
        @(negedge ACLK);
        ARESET = 1'b0;
        chk("t5_busy", busy, 0);
        chk("t5_m_init", m_init, 0);
        chk("t5_m_wr", m_wr, 0);
        chk("t5_m_addr", m_addr, 0);
        chk("t5_txn", txn_count, 0);
        chk("t5_errc", err_count, 0);
        a0 = ack_cnt;
        repeat (6) @(negedge ACLK);
        chk("t5_no_ack", ack_cnt, a0);
        resp_delay = 2; resp_rdata = 32'h12345678;
        disp_target = disp_target + 1;
        wait_disp(disp_target, 40);
        repeat (2) @(negedge ACLK);
        chk("t5_fresh_rdata", disp_rdata, 32'h12345678);
        chk("t5_fresh_txn", txn_count, 1);

        // Saturation.
        resp_delay = 1; resp_err = 1'b1; disp_addr = 32'h700;
        disp_target = disp_target + 260;
        wait_disp(disp_target, 3000);
        repeat (2) @(negedge ACLK);
        chk("t6_err_sat", err_count, 8'hFF);
        chk("t6_txn", txn_count, 16'h0105);
        chk_hold = 1'b1;
        @(negedge ACLK);
        force dut.txn_count_q = 16'hFFFD;
        preload_val = 16'hFFFD;
        preload_en = 1'b1;
        @(negedge ACLK);
        release dut.txn_count_q;
        preload_en = 1'b0;
        @(negedge ACLK);
        chk_hold = 1'b0;
        chk("t6_preload", txn_count, 16'hFFFD);
        resp_err = 1'b0;
        disp_target = disp_target + 3;
        wait_disp(disp_target, 60);
        repeat (2) @(negedge ACLK);
        chk("t6_txn_sat", txn_count, 16'hFFFF);
        chk("t6_err_hold", err_count, 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
